// File: rtl/mem_err_monitor.sv
// mem_err_monitor: counts MEM1/MEM2 ECC events, logs first uncorrectable failure, WARN/FAULT escalation with req/ack clear
module mem_err_monitor #(
  parameter int CNT_W       = 8,
  parameter int ADDR_W      = 8,
  parameter int CORR_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem1_err_detected,
  input  logic              mem1_err_corrected,
  input  logic [ADDR_W-1:0] mem1_addr,
  input  logic              mem2_err_detected,
  input  logic              mem2_err_corrected,
  input  logic [ADDR_W-1:0] mem2_addr,
  input  logic              clr_req,
  output logic              clr_ack,
  output logic [CNT_W-1:0]  mem1_corr_cnt,
  output logic [CNT_W-1:0]  mem1_uncorr_cnt,
  output logic [CNT_W-1:0]  mem2_corr_cnt,
  output logic [CNT_W-1:0]  mem2_uncorr_cnt,
  output logic              first_fail_valid,
  output logic              first_fail_src,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              warn,
  output logic              fault_irq,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {IDLE = 2'd0, WARN = 2'd1, FAULT = 2'd2, CLEAR = 2'd3} state_t;
  state_t state_q, state_d;
  logic m1_prev_q, m2_prev_q, clr_prev_q;
  logic [CNT_W-1:0] m1_corr_q, m1_corr_d, m1_unc_q, m1_unc_d, m2_corr_q, m2_corr_d, m2_unc_q, m2_unc_d;
  logic ff_valid_q, ff_valid_d, ff_src_q, ff_src_d;
  logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
  logic warn_q, warn_d, fault_q, fault_d, ack_q, ack_d;
  logic c1, u1, c2, u2, clr_edge, zero, any_unc, log_en;
  logic [CNT_W:0] corr_total;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
    return clr ? CNT_W'(inc) : (inc && c != '1) ? c + 1'b1 : c;
  endfunction
  always_comb begin
    c1 = mem1_err_detected & ~m1_prev_q & mem1_err_corrected;
    u1 = mem1_err_detected & ~m1_prev_q & ~mem1_err_corrected;
    c2 = mem2_err_detected & ~m2_prev_q & mem2_err_corrected;
    u2 = mem2_err_detected & ~m2_prev_q & ~mem2_err_corrected;
    clr_edge = clr_req & ~clr_prev_q;
    corr_total = {1'b0, m1_corr_q} + {1'b0, m2_corr_q};
    any_unc = (|m1_unc_q) | (|m2_unc_q);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = clr_edge ? CLEAR : any_unc ? FAULT : (corr_total >= (CNT_W+1)'(CORR_THRESH)) ? WARN : IDLE;
      WARN:    state_d = clr_edge ? CLEAR : any_unc ? FAULT : WARN;
      FAULT:   state_d = clr_edge ? CLEAR : FAULT;
      default: state_d = IDLE;
    endcase
    // Counters and log restart on the edge that enters CLEAR; a same-cycle event lands in the fresh state.
    zero = clr_edge && state_q != CLEAR;
    m1_corr_d = bump(m1_corr_q, c1, zero);
    m1_unc_d = bump(m1_unc_q, u1, zero);
    m2_corr_d = bump(m2_corr_q, c2, zero);
    m2_unc_d = bump(m2_unc_q, u2, zero);
    log_en = (zero | ~ff_valid_q) & (u1 | u2);
    ff_valid_d = log_en ? 1'b1 : zero ? 1'b0 : ff_valid_q;
    ff_src_d = log_en ? ~u1 : zero ? 1'b0 : ff_src_q;
    ff_addr_d = log_en ? (u1 ? mem1_addr : mem2_addr) : zero ? '0 : ff_addr_q;
    warn_d = state_d == WARN;
    fault_d = state_d == FAULT;
    ack_d = state_d == CLEAR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m1_prev_q <= 1'b0;
      m2_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      m1_corr_q <= '0;
      m1_unc_q <= '0;
      m2_corr_q <= '0;
      m2_unc_q <= '0;
      ff_valid_q <= 1'b0;
      ff_src_q <= 1'b0;
      ff_addr_q <= '0;
      warn_q <= 1'b0;
      fault_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m1_prev_q <= mem1_err_detected;
      m2_prev_q <= mem2_err_detected;
      clr_prev_q <= clr_req;
      m1_corr_q <= m1_corr_d;
      m1_unc_q <= m1_unc_d;
      m2_corr_q <= m2_corr_d;
      m2_unc_q <= m2_unc_d;
      ff_valid_q <= ff_valid_d;
      ff_src_q <= ff_src_d;
      ff_addr_q <= ff_addr_d;
      warn_q <= warn_d;
      fault_q <= fault_d;
      ack_q <= ack_d;
    end
  end
  assign clr_ack = ack_q;
  assign mem1_corr_cnt = m1_corr_q;
  assign mem1_uncorr_cnt = m1_unc_q;
  assign mem2_corr_cnt = m2_corr_q;
  assign mem2_uncorr_cnt = m2_unc_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_src = ff_src_q;
  assign first_fail_addr = ff_addr_q;
  assign warn = warn_q;
  assign fault_irq = fault_q;
  assign state = state_q;
endmodule

// File: tb/tb_mem_err_monitor.sv
// tb_mem_err_monitor: scoreboard bench for mem_err_monitor
module tb_mem_err_monitor;
  localparam int S_C1 = 0, S_U1 = 1, S_C2 = 2, S_U2 = 3, S_FV = 4, S_FS = 5, S_FA = 6, S_W = 7, S_F = 8, S_ST = 9, S_ACK = 10;
  logic clk = 1'b0, rst;
  logic m1_det, m1_cor, m2_det, m2_cor, clr_req;
  logic [7:0] m1_addr, m2_addr;
  logic clr_ack, ff_valid, ff_src, warn, fault_irq;
  logic [7:0] c1, u1, c2, u2, ff_addr;
  logic [1:0] state;
  int n_cmp = 0, n_err = 0;
  typedef struct {string tag; int sel; int exp;} exp_t;
  exp_t exp_q[$];
  mem_err_monitor #(.CNT_W(8), .ADDR_W(8), .CORR_THRESH(4)) dut (
    .clk(clk), .rst(rst),
    .mem1_err_detected(m1_det), .mem1_err_corrected(m1_cor), .mem1_addr(m1_addr),
    .mem2_err_detected(m2_det), .mem2_err_corrected(m2_cor), .mem2_addr(m2_addr),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .mem1_corr_cnt(c1), .mem1_uncorr_cnt(u1), .mem2_corr_cnt(c2), .mem2_uncorr_cnt(u2),
    .first_fail_valid(ff_valid), .first_fail_src(ff_src), .first_fail_addr(ff_addr),
    .warn(warn), .fault_irq(fault_irq), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int obs_of(input int sel);
    case (sel)
      S_C1: return int'(c1);
      S_U1: return int'(u1);
      S_C2: return int'(c2);
      S_U2: return int'(u2);
      S_FV: return int'(ff_valid);
      S_FS: return int'(ff_src);
      S_FA: return int'(ff_addr);
      S_W: return int'(warn);
      S_F: return int'(fault_irq);
      S_ST: return int'(state);
      default: return int'(clr_ack);
    endcase
  endfunction
  task automatic push(input string tag, input int sel, input int exp);
    exp_q.push_back('{tag, sel, exp});
  endtask
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, obs_of(e.sel), e.exp);
    end
  endtask
  task automatic pulse1(input logic cor, input logic [7:0] a);
    @(negedge clk);
    m1_det = 1'b1;
    m1_cor = cor;
    m1_addr = a;
    @(negedge clk);
    m1_det = 1'b0;
  endtask
  initial begin
    int acks, m;
    rst = 1'b1;
    {m1_det, m1_cor, m2_det, m2_cor, clr_req} = '0;
    m1_addr = 8'h00;
    m2_addr = 8'h00;
    repeat (3) @(negedge clk);
    push("rst_c1", S_C1, 0); push("rst_u2", S_U2, 0); push("rst_fv", S_FV, 0);
    push("rst_warn", S_W, 0); push("rst_fault", S_F, 0); push("rst_ack", S_ACK, 0); push("rst_state", S_ST, 0);
    drain();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pulse1(1'b1, 8'h30);
    push("t2_c1", S_C1, 4); push("t2_warn_early", S_W, 0);
    drain();
    @(negedge clk);
    push("t2_warn", S_W, 1); push("t2_fault", S_F, 0); push("t2_state", S_ST, 1);
    drain();
    @(negedge clk);
    m2_det = 1'b1; m2_cor = 1'b0; m2_addr = 8'h5A;
    push("t3_u2", S_U2, 1); push("t3_fv", S_FV, 1); push("t3_src", S_FS, 1);
    push("t3_addr", S_FA, 8'h5A); push("t3_fault", S_F, 1); push("t3_warn", S_W, 0);
    repeat (10) @(negedge clk);
    m2_det = 1'b0;
    drain();
    clr_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acks += int'(clr_ack);
    end
    push("t6_c1", S_C1, 0); push("t6_u2", S_U2, 0); push("t6_fv", S_FV, 0);
    push("t6_addr", S_FA, 0); push("t6_state", S_ST, 0); push("t6_fault", S_F, 0);
    drain();
    check("t6_ack_pulses", acks, 1);
    clr_req = 1'b0;
    @(negedge clk);
    clr_req = 1'b1; m1_det = 1'b1; m1_cor = 1'b1;
    @(negedge clk);
    m1_det = 1'b0;
    push("t6z_c1", S_C1, 1); push("t6z_state", S_ST, 3); push("t6z_ack", S_ACK, 1);
    drain();
    @(negedge clk);
    push("t6z_idle", S_ST, 0); push("t6z_ack_off", S_ACK, 0); push("t6z_c1_keep", S_C1, 1);
    drain();
    clr_req = 1'b0;
    @(negedge clk);
    m1_det = 1'b1; m1_cor = 1'b0; m1_addr = 8'h11;
    m2_det = 1'b1; m2_cor = 1'b0; m2_addr = 8'h22;
    @(negedge clk);
    m1_det = 1'b0; m2_det = 1'b0;
    push("t4_u1", S_U1, 1); push("t4_u2", S_U2, 1); push("t4_fv", S_FV, 1);
    push("t4_src", S_FS, 0); push("t4_addr", S_FA, 8'h11);
    drain();
    @(negedge clk);
    push("t4_fault", S_F, 1); push("t4_state", S_ST, 2);
    drain();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    push("clr2_ack", S_ACK, 1); push("clr2_u1", S_U1, 0);
    drain();
    @(negedge clk);
    m = 0;
    for (int i = 0; i < 300; i++) begin
      pulse1(1'b1, 8'h40);
      m = (m == 255) ? m : m + 1;
    end
    push("t5_c1_sat", S_C1, m); push("t5_c2", S_C2, 0);
    drain();
    @(negedge clk);
    push("t5_warn", S_W, 1); push("t5_state", S_ST, 1);
    drain();
    #2 rst = 1'b1;
    #1;
    push("arst_c1", S_C1, 0); push("arst_warn", S_W, 0); push("arst_state", S_ST, 0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push("post_rst_c1", S_C1, 0); push("post_rst_state", S_ST, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
